// File: rtl/offset_divider_pkg.sv
// offset_divider_pkg: shared widths, state encoding and word type for the offset divider
//  W    : operand/quotient/remainder width, tied to the leading-one detector width
//  LOCW : leading-one location width (0 = zero word, k = MSB one at bit k-1)
//  DW   : width of the pre-aligned divisor (W + max shift of W-1)
package offset_divider_pkg;
   localparam int W    = 10;
   localparam int LOCW = 4;
   localparam int DW   = W + 9;
   typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} div_state_t;
   typedef logic [W-1:0] word_t;
endpackage

// File: rtl/offset_divider_seq_lod.sv
// offset_divider_seq_lod: combinational leading-one location of a W-bit word
//  word : input word
//  loc  : 0 when word is zero, otherwise index of the most significant one plus 1
module offset_divider_seq_lod
   import offset_divider_pkg::*;
(
   input  word_t           word,
   output logic [LOCW-1:0] loc
);
   always_comb begin
      loc = '0;
      for (int i = 0; i < W; i++)
         if (word[i]) loc = LOCW'(i + 1);
   end
endmodule

// File: rtl/offset_divider_seq.sv
// offset_divider_seq: sequential restoring divider with leading-one pre-alignment of the divisor
//  clk, rst_n            : clock, asynchronous active-low reset
//  in_valid / in_ready   : operand handshake, accepted only while idle
//  dividend, divisor     : unsigned W-bit operands
//  out_valid / out_ready : result handshake, result held until accepted
//  quotient, remainder   : unsigned W-bit results
//  div_by_zero           : divisor was zero for the presented result
module offset_divider_seq
   import offset_divider_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  word_t dividend,
   input  word_t divisor,
   output logic  out_valid,
   input  logic  out_ready,
   output word_t quotient,
   output word_t remainder,
   output logic  div_by_zero
);
   div_state_t      state, state_nx;
   word_t           a_r, b_r, q_r, rem_r;
   logic [DW-1:0]   dsh_r;
   logic [LOCW-1:0] cnt_r, loc_a, loc_b, shift;
   logic            dbz_r, fast, ge;

   offset_divider_seq_lod lod_dividend (.word(a_r), .loc(loc_a));
   offset_divider_seq_lod lod_divisor  (.word(b_r), .loc(loc_b));

   // shift is only meaningful on the normal path (a_r >= b_r > 0)
   assign shift       = loc_a - loc_b;
   assign fast        = (b_r == '0) || (a_r < b_r);
   assign ge          = DW'(rem_r) >= dsh_r;
   assign in_ready    = state == IDLE;
   assign out_valid   = state == DONE;
   assign quotient    = q_r;
   assign remainder   = rem_r;
   assign div_by_zero = dbz_r;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? NORM : IDLE;
         NORM:    state_nx = fast ? DONE : ITER;
         ITER:    state_nx = cnt_r == LOCW'(1) ? DONE : ITER;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         q_r   <= '0;
         rem_r <= '0;
         dsh_r <= '0;
         cnt_r <= '0;
         dbz_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r <= dividend;
               b_r <= divisor;
            end
            NORM: begin
               // zero divisor saturates the quotient; a_r < b_r needs no iterations
               q_r   <= b_r == '0 ? '1 : '0;
               rem_r <= a_r;
               dbz_r <= b_r == '0;
               dsh_r <= DW'(b_r) << shift;
               cnt_r <= shift + LOCW'(1);
            end
            ITER: begin
               rem_r <= ge ? rem_r - dsh_r[W-1:0] : rem_r;
               q_r   <= {q_r[W-2:0], ge};
               dsh_r <= dsh_r >> 1;
               cnt_r <= cnt_r - LOCW'(1);
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_offset_divider_seq.sv
// tb_offset_divider_seq: directed and randomized self-checking bench for offset_divider_seq
module tb_offset_divider_seq;
   logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic [9:0] dividend = 0, divisor = 0;
   logic       in_ready, out_valid, div_by_zero;
   logic [9:0] quotient, remainder;
   int         checks = 0, errors = 0;

   offset_divider_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic op(input int a, input int b, input int eq, input int er, input int ed,
                     input int el, input int hold);
      int    lat;
      string t;
      t = $sformatf("%0d/%0d", a, b);
      @(negedge clk);
      chk({t, " in_ready"}, int'(in_ready), 1);
      dividend = 10'(a);
      divisor  = 10'(b);
      in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      dividend = 10'($urandom);
      divisor  = 10'($urandom);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({t, " latency"}, lat, el);
      chk({t, " quotient"}, int'(quotient), eq);
      chk({t, " remainder"}, int'(remainder), er);
      chk({t, " dbz"}, int'(div_by_zero), ed);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         dividend = 10'($urandom);
         divisor  = 10'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk({t, " hold out_valid"}, int'(out_valid), 1);
         chk({t, " hold in_ready"}, int'(in_ready), 0);
         chk({t, " hold quotient"}, int'(quotient), eq);
         chk({t, " hold remainder"}, int'(remainder), er);
         chk({t, " hold dbz"}, int'(div_by_zero), ed);
      end
      in_valid  = 0;
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 0;
      chk({t, " drop out_valid"}, int'(out_valid), 0);
      chk({t, " back in_ready"}, int'(in_ready), 1);
   endtask

   initial begin
      int a, b, eq, er, ed, el;
      @(negedge clk);
      chk("reset in_ready", int'(in_ready), 1);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset quotient", int'(quotient), 0);
      chk("reset remainder", int'(remainder), 0);
      chk("reset dbz", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1;
      op(100, 7, 14, 2, 0, 6, 0);
      op(9, 9, 1, 0, 0, 2, 0);
      op(1023, 1, 1023, 0, 0, 11, 0);
      op(37, 0, 1023, 37, 1, 1, 0);
      op(5, 9, 0, 5, 0, 1, 0);
      op(0, 5, 0, 0, 0, 1, 0);
      op(1, 1, 1, 0, 0, 2, 0);
      op(1000, 3, 333, 1, 0, 10, 0);
      op(512, 2, 256, 0, 0, 10, 0);
      op(0, 0, 1023, 0, 1, 1, 0);
      op(100, 7, 14, 2, 0, 6, 5);
      // reset pulse while 1023/1 is iterating
      @(negedge clk);
      dividend = 10'd1023;
      divisor  = 10'd1;
      in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      repeat (4) @(negedge clk);
      rst_n = 0;
      #1;
      chk("midop reset out_valid", int'(out_valid), 0);
      chk("midop reset in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1;
      repeat (12) @(negedge clk);
      chk("after reset out_valid", int'(out_valid), 0);
      chk("after reset in_ready", int'(in_ready), 1);
      op(100, 7, 14, 2, 0, 6, 0);
      for (int n = 0; n < 300; n++) begin
         a  = int'($urandom_range(0, 1023));
         b  = (n % 7 == 0) ? 0 : int'($urandom_range(1, (n % 3 == 0) ? 15 : 1023));
         eq = b == 0 ? 1023 : a / b;
         er = b == 0 ? a : a % b;
         ed = b == 0 ? 1 : 0;
         el = (b == 0 || a < b) ? 1 : $clog2(a + 1) - $clog2(b + 1) + 2;
         op(a, b, eq, er, ed, el, int'($urandom_range(0, 3)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
